// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer: FSM state encodings and counter widths.
package pwm_pkg;

    localparam int FAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SOFTSTART = 3'd1,
        ST_RUN       = 3'd2,
        ST_FAULT     = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_duty_sequencer_slew.sv
// Combinational bounded slew step: moves cur toward target by at most step, result kept in [DUTY_MIN, DUTY_MAX].
module duty_slew_step #(
    parameter int BIT_WIDTH = 21,
    parameter int DUTY_MIN  = 10,
    parameter int DUTY_MAX  = 190
) (
    input  logic [BIT_WIDTH-1:0] i_cur,
    input  logic [BIT_WIDTH-1:0] i_target,
    input  logic [BIT_WIDTH-1:0] i_step,
    output logic [BIT_WIDTH-1:0] o_next
);

    logic [BIT_WIDTH:0] w_cur_x;
    logic [BIT_WIDTH:0] w_tgt_x;
    logic [BIT_WIDTH:0] w_step_x;
    logic [BIT_WIDTH:0] w_next_x;

    assign w_cur_x  = {1'b0, i_cur};
    assign w_tgt_x  = {1'b0, i_target};
    assign w_step_x = {1'b0, i_step};

    // One extra bit keeps the sum from wrapping; the down path compares before subtracting.
    always_comb begin
        w_next_x = w_cur_x;
        if (w_cur_x < w_tgt_x) begin
            if ((w_cur_x + w_step_x) >= w_tgt_x) begin
                w_next_x = w_tgt_x;
            end else begin
                w_next_x = w_cur_x + w_step_x;
            end
        end else if (w_cur_x > w_tgt_x) begin
            if (w_cur_x <= (w_tgt_x + w_step_x)) begin
                w_next_x = w_tgt_x;
            end else begin
                w_next_x = w_cur_x - w_step_x;
            end
        end else begin
            w_next_x = w_cur_x;
        end
    end

    // Final clamp so a bad target can never push duty outside the bridge-safe window.
    always_comb begin
        if (w_next_x > (BIT_WIDTH+1)'(DUTY_MAX)) begin
            o_next = BIT_WIDTH'(DUTY_MAX);
        end else if (w_next_x < (BIT_WIDTH+1)'(DUTY_MIN)) begin
            o_next = BIT_WIDTH'(DUTY_MIN);
        end else begin
            o_next = w_next_x[BIT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer feeding the complementary PWM bridge: command clamp, slew-limited ramp on
// carrier sync, soft-start, and latched fault protection with a sync-counted re-arm holdoff.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH       = 21,
    parameter int DUTY_MIN        = 10,
    parameter int DUTY_MAX        = 190,
    parameter int STEP            = 4,
    parameter int SS_STEP         = 1,
    parameter int HOLDOFF_PERIODS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sync,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BIT_WIDTH-1:0]   cmd_duty,
    input  logic                   fault_in,
    input  logic                   fault_clr,
    output logic [BIT_WIDTH-1:0]   duty,
    output logic                   protection,
    output logic [2:0]             state,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int HC_W = (HOLDOFF_PERIODS > 1) ? $clog2(HOLDOFF_PERIODS) : 1;
    localparam logic [BIT_WIDTH-1:0] DMIN = BIT_WIDTH'(DUTY_MIN);
    localparam logic [BIT_WIDTH-1:0] DMAX = BIT_WIDTH'(DUTY_MAX);

    state_t                 r_state;
    logic [BIT_WIDTH-1:0]   r_duty;
    logic [BIT_WIDTH-1:0]   r_target;
    logic                   r_prot;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;
    logic [HC_W-1:0]        r_hold_cnt;

    state_t                 w_nxt_state;
    logic [BIT_WIDTH-1:0]   w_nxt_duty;
    logic [BIT_WIDTH-1:0]   w_nxt_target;
    logic                   w_nxt_prot;
    logic [FAULT_CNT_W-1:0] w_nxt_fault_cnt;
    logic [HC_W-1:0]        w_nxt_hold_cnt;

    logic                   w_accept;
    logic                   w_fault_entry;
    logic [BIT_WIDTH-1:0]   w_cmd_clamped;
    logic [BIT_WIDTH-1:0]   w_step;
    logic [BIT_WIDTH-1:0]   w_slew_duty;

    assign cmd_ready     = (r_state != ST_FAULT) && (r_state != ST_HOLDOFF);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_fault_entry = fault_in && (r_state != ST_OFF) && (r_state != ST_FAULT);
    assign w_step        = (r_state == ST_RUN) ? BIT_WIDTH'(STEP) : BIT_WIDTH'(SS_STEP);

    assign duty        = r_duty;
    assign protection  = r_prot;
    assign state       = r_state;
    assign fault_count = r_fault_cnt;

    // Clamp the incoming command into the legal duty window.
    always_comb begin
        if (cmd_duty > DMAX) begin
            w_cmd_clamped = DMAX;
        end else if (cmd_duty < DMIN) begin
            w_cmd_clamped = DMIN;
        end else begin
            w_cmd_clamped = cmd_duty;
        end
    end

    duty_slew_step #(
        .BIT_WIDTH (BIT_WIDTH),
        .DUTY_MIN  (DUTY_MIN),
        .DUTY_MAX  (DUTY_MAX)
    ) u_slew (
        .i_cur    (r_duty),
        .i_target (r_target),
        .i_step   (w_step),
        .o_next   (w_slew_duty)
    );

    // Next-state logic: fault entry first, then enable drop, then sync-driven ramp/holdoff events.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_duty      = r_duty;
        w_nxt_prot      = r_prot;
        w_nxt_fault_cnt = r_fault_cnt;
        w_nxt_hold_cnt  = r_hold_cnt;
        // Ramp below reads r_target, so a command landing with sync only takes effect next period.
        w_nxt_target    = w_accept ? w_cmd_clamped : r_target;

        if (w_fault_entry) begin
            w_nxt_state = ST_FAULT;
            w_nxt_prot  = 1'b1;
            w_nxt_duty  = DMIN;
            if (r_fault_cnt != {FAULT_CNT_W{1'b1}}) begin
                w_nxt_fault_cnt = r_fault_cnt + FAULT_CNT_W'(1);
            end else begin
                w_nxt_fault_cnt = r_fault_cnt;
            end
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_nxt_prot = 1'b1;
                    w_nxt_duty = DMIN;
                    if (en && sync) begin
                        w_nxt_state = ST_SOFTSTART;
                        w_nxt_prot  = 1'b0;
                    end else begin
                        w_nxt_state = ST_OFF;
                    end
                end
                ST_SOFTSTART, ST_RUN: begin
                    if (!en) begin
                        w_nxt_state = ST_OFF;
                        w_nxt_prot  = 1'b1;
                        w_nxt_duty  = DMIN;
                    end else if (sync) begin
                        if ((r_state == ST_SOFTSTART) && (r_duty == r_target)) begin
                            w_nxt_state = ST_RUN;
                        end else begin
                            w_nxt_duty = w_slew_duty;
                        end
                    end else begin
                        w_nxt_state = r_state;
                    end
                end
                ST_FAULT: begin
                    w_nxt_prot = 1'b1;
                    w_nxt_duty = DMIN;
                    if (fault_clr && !fault_in) begin
                        w_nxt_state    = ST_HOLDOFF;
                        w_nxt_hold_cnt = HC_W'(0);
                    end else begin
                        w_nxt_state = ST_FAULT;
                    end
                end
                ST_HOLDOFF: begin
                    w_nxt_prot = 1'b1;
                    w_nxt_duty = DMIN;
                    if (sync) begin
                        if (r_hold_cnt == HC_W'(HOLDOFF_PERIODS - 1)) begin
                            w_nxt_hold_cnt = HC_W'(0);
                            if (en) begin
                                w_nxt_state = ST_SOFTSTART;
                                w_nxt_prot  = 1'b0;
                            end else begin
                                w_nxt_state = ST_OFF;
                            end
                        end else begin
                            w_nxt_hold_cnt = r_hold_cnt + HC_W'(1);
                        end
                    end else begin
                        w_nxt_state = ST_HOLDOFF;
                    end
                end
                default: begin
                    w_nxt_state = ST_OFF;
                    w_nxt_prot  = 1'b1;
                    w_nxt_duty  = DMIN;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_duty      <= DMIN;
            r_target    <= DMIN;
            r_prot      <= 1'b1;
            r_fault_cnt <= {FAULT_CNT_W{1'b0}};
            r_hold_cnt  <= {HC_W{1'b0}};
        end else begin
            r_state     <= w_nxt_state;
            r_duty      <= w_nxt_duty;
            r_target    <= w_nxt_target;
            r_prot      <= w_nxt_prot;
            r_fault_cnt <= w_nxt_fault_cnt;
            r_hold_cnt  <= w_nxt_hold_cnt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: soft-start, slew/clamp, fault latch, holdoff and async reset.
module tb_pwm_duty_sequencer;

    localparam int W   = 21;
    localparam int GAP = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sync;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_duty;
    logic         fault_in;
    logic         fault_clr;
    logic [W-1:0] duty;
    logic         protection;
    logic [2:0]   state;
    logic [7:0]   fault_count;

    int n_pass = 0;
    int n_total = 0;

    pwm_duty_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_duty    (cmd_duty),
        .fault_in    (fault_in),
        .fault_clr   (fault_clr),
        .duty        (duty),
        .protection  (protection),
        .state       (state),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync();
        repeat (GAP) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic send_cmd(input int d);
        cmd_valid = 1'b1;
        cmd_duty  = W'(d);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; cmd_valid = 1'b0;
        cmd_duty = '0; fault_in = 1'b0; fault_clr = 1'b0;
        tick(); tick();
        chk("rst_duty", 32'(duty), 32'd10);
        chk("rst_prot", 32'(protection), 32'd1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_fcnt", 32'(fault_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Soft-start toward 15
        send_cmd(15);
        en = 1'b1;
        do_sync();
        chk("ss_state", 32'(state), 32'd1);
        chk("ss_prot", 32'(protection), 32'd0);
        chk("ss_duty0", 32'(duty), 32'd10);
        for (int k = 1; k <= 5; k++) begin
            do_sync();
            chk("ss_ramp", 32'(duty), 32'(10 + k));
        end
        do_sync();
        chk("run_state", 32'(state), 32'd2);
        chk("run_duty", 32'(duty), 32'd15);

        // Upward slew with high clamp
        send_cmd(500);
        do_sync(); chk("up1", 32'(duty), 32'd19);
        do_sync(); chk("up2", 32'(duty), 32'd23);
        repeat (41) do_sync();
        chk("up_187", 32'(duty), 32'd187);
        do_sync(); chk("up_clamp", 32'(duty), 32'd190);
        do_sync(); chk("up_hold", 32'(duty), 32'd190);

        // Downward slew with low clamp
        send_cmd(3);
        do_sync(); chk("dn1", 32'(duty), 32'd186);
        repeat (43) do_sync();
        chk("dn_14", 32'(duty), 32'd14);
        do_sync(); chk("dn_min", 32'(duty), 32'd10);
        do_sync(); chk("dn_hold", 32'(duty), 32'd10);
        send_cmd(13);
        do_sync(); chk("part_up", 32'(duty), 32'd13);
        send_cmd(3);
        do_sync(); chk("part_dn", 32'(duty), 32'd10);

        // Accept coincident with sync: ramp uses old target
        repeat (GAP) tick();
        sync = 1'b1; cmd_valid = 1'b1; cmd_duty = W'(48);
        tick();
        sync = 1'b0; cmd_valid = 1'b0;
        chk("coinc_old", 32'(duty), 32'd10);
        do_sync(); chk("coinc_new", 32'(duty), 32'd14);

        // Fault coincident with sync
        repeat (GAP) tick();
        sync = 1'b1; fault_in = 1'b1;
        tick();
        sync = 1'b0; fault_in = 1'b0;
        chk("flt_prot", 32'(protection), 32'd1);
        chk("flt_duty", 32'(duty), 32'd10);
        chk("flt_cnt1", 32'(fault_count), 32'd1);
        chk("flt_state", 32'(state), 32'd3);
        chk("flt_ready", 32'(cmd_ready), 32'd0);
        fault_in = 1'b1; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_ignored", 32'(state), 32'd3);
        chk("held_cnt", 32'(fault_count), 32'd1);
        fault_in = 1'b0;
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("hold_state", 32'(state), 32'd4);
        chk("hold_prot", 32'(protection), 32'd1);
        repeat (7) do_sync();
        chk("hold_7", 32'(state), 32'd4);
        do_sync();
        chk("rearm_state", 32'(state), 32'd1);
        chk("rearm_prot", 32'(protection), 32'd0);
        chk("rearm_duty", 32'(duty), 32'd10);

        // Re-fault during holdoff
        do_sync(); chk("ss2_duty", 32'(duty), 32'd11);
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        chk("flt2_state", 32'(state), 32'd3);
        chk("flt2_cnt", 32'(fault_count), 32'd2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("hold2_state", 32'(state), 32'd4);
        do_sync();
        do_sync();
        cmd_valid = 1'b1; cmd_duty = W'(120);
        #1;
        chk("hold_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        repeat (GAP) tick();
        sync = 1'b1; fault_in = 1'b1;
        tick();
        sync = 1'b0; fault_in = 1'b0;
        chk("reflt_state", 32'(state), 32'd3);
        chk("reflt_cnt", 32'(fault_count), 32'd3);
        chk("reflt_prot", 32'(protection), 32'd1);

        // Re-arm, soft-start to 48 (rejected 120 must not appear), then ramp to 100
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        repeat (8) do_sync();
        chk("rearm2_state", 32'(state), 32'd1);
        repeat (38) do_sync();
        chk("ss48_duty", 32'(duty), 32'd48);
        chk("ss48_state", 32'(state), 32'd1);
        do_sync();
        chk("run48_state", 32'(state), 32'd2);
        send_cmd(190);
        repeat (13) do_sync();
        chk("mid_100", 32'(duty), 32'd100);

        // Async reset mid-ramp
        rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty), 32'd10);
        chk("arst_prot", 32'(protection), 32'd1);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_fcnt", 32'(fault_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_sync();
        chk("post_ss", 32'(state), 32'd1);
        do_sync();
        chk("post_tgt_run", 32'(state), 32'd2);
        chk("post_tgt_duty", 32'(duty), 32'd10);

        // Enable drop from RUN
        send_cmd(30);
        do_sync(); chk("en_ramp", 32'(duty), 32'd14);
        en = 1'b0;
        tick();
        chk("enlo_state", 32'(state), 32'd0);
        chk("enlo_prot", 32'(protection), 32'd1);
        chk("enlo_duty", 32'(duty), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
